// File: rtl/pwr_cntr_sched_pkg.sv
// Shared definitions for the power-activity counter scheduler: FSM encoding,
// default bank geometry and the full-scale counter value.
package pwr_cntr_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam int unsigned DEF_NREQ = 4;
   localparam int unsigned DEF_NCNT = 8;
   localparam int unsigned DEF_CW   = 16;

   // Counters hold here instead of wrapping.
   localparam logic [DEF_CW-1:0] DEF_SAT = '1;

endpackage

// File: rtl/pwr_cntr_sched_rr_arb.sv
// Round-robin priority picker: first asserted request at or above ptr,
// wrapping modulo N. Produces a one-hot grant, its index and a valid flag.
module rr_arb #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_vld
);

   int unsigned   cand;
   logic [PW-1:0] ci;

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = 0;
      ci      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = (32'(ptr) + k) % N;
         ci   = PW'(cand);
         if (!gnt_vld && req[ci]) begin
            gnt[ci] = 1'b1;
            gnt_idx = ci;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwr_cntr_sched.sv
// Power-activity counter bank: round-robin increment scheduling with
// saturation, a registered read port and a one-counter-per-cycle bank clear.
module pwr_cntr_sched
   import pwr_cntr_sched_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ,
   parameter int unsigned NCNT = DEF_NCNT,
   parameter int unsigned IW   = $clog2(NCNT),
   parameter int unsigned CW   = DEF_CW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [NREQ-1:0]    ev_valid,
   input  logic [NREQ*IW-1:0] ev_idx,
   output logic [NREQ-1:0]    ev_ready,
   input  logic               clr,
   output logic               clr_busy,
   input  logic               rd_en,
   input  logic [IW-1:0]      rd_idx,
   output logic               rd_valid,
   output logic [CW-1:0]      rd_data,
   output logic [NCNT-1:0]    sat
);

   localparam int unsigned   RW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] SAT_MAX = '1;

   state_t          state_q, state_d;
   logic [RW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   cidx_q, cidx_d;
   logic [CW-1:0]   cnt_q [NCNT];
   logic [CW-1:0]   cnt_d [NCNT];
   logic [NCNT-1:0] sat_q, sat_d;
   logic            rd_valid_q, rd_valid_d;
   logic [CW-1:0]   rd_data_q, rd_data_d;

   logic [NREQ-1:0] gnt;
   logic [RW-1:0]   gnt_idx;
   logic            gnt_vld;
   logic            grant_ok;
   logic            xfer;
   logic [IW-1:0]   xidx;

   rr_arb #(.N(NREQ), .PW(RW)) u_arb (
      .req     (ev_valid),
      .ptr     (rr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // en gates the grant directly so it drops in the same cycle en falls.
   assign grant_ok = (state_q == ST_RUN) && en;
   assign ev_ready = grant_ok ? gnt : '0;
   assign xfer     = grant_ok && gnt_vld;
   assign xidx     = ev_idx[32'(gnt_idx)*IW +: IW];

   always_comb begin
      state_d = state_q;
      cidx_d  = '0;
      case (state_q)
         ST_IDLE:  if (clr) state_d = ST_CLEAR; else if (en)  state_d = ST_RUN;
         ST_RUN:   if (clr) state_d = ST_CLEAR; else if (!en) state_d = ST_IDLE;
         ST_CLEAR: begin
            cidx_d = cidx_q + IW'(1);
            if (cidx_q == IW'(NCNT-1)) begin
               cidx_d  = '0;
               state_d = en ? ST_RUN : ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      rr_d  = rr_q;
      if (xfer) begin
         if (cnt_q[xidx] == SAT_MAX) sat_d[xidx] = 1'b1;
         else                        cnt_d[xidx] = cnt_q[xidx] + CW'(1);
         rr_d = (gnt_idx == RW'(NREQ-1)) ? '0 : gnt_idx + RW'(1);
      end
      if (state_q == ST_CLEAR) begin
         cnt_d[cidx_q] = '0;
         sat_d[cidx_q] = 1'b0;
      end
      // Reads see the pre-update value, so a same-cycle increment is not visible.
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? cnt_q[rd_idx] : rd_data_q;
   end

   // NOTE: the counter bank is flops, not RAM, and must zero on reset, so it is reset in a loop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_q       <= '0;
         cidx_q     <= '0;
         sat_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cidx_q     <= cidx_d;
         sat_q      <= sat_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         cnt_q      <= cnt_d;
      end
   end

   assign clr_busy = (state_q == ST_CLEAR);
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_pwr_cntr_sched.sv
// Directed bench for pwr_cntr_sched: a 16-bit instance for the main checks and
// a 4-bit instance sharing the same stimulus for saturation behaviour.
module tb_pwr_cntr_sched;

   logic        clk, reset, en, clr, rd_en;
   logic [3:0]  ev_valid;
   logic [11:0] ev_idx;
   logic [2:0]  rd_idx;

   logic [3:0]  ev_ready, ev_ready4;
   logic        clr_busy, clr_busy4, rd_valid, rd_valid4;
   logic [15:0] rd_data;
   logic [3:0]  rd_data4;
   logic [7:0]  sat, sat4;

   int n_total = 0;
   int n_bad   = 0;

   pwr_cntr_sched u_dut (
      .clk(clk), .reset(reset), .en(en), .ev_valid(ev_valid), .ev_idx(ev_idx),
      .ev_ready(ev_ready), .clr(clr), .clr_busy(clr_busy), .rd_en(rd_en),
      .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .sat(sat)
   );

   pwr_cntr_sched #(.CW(4)) u_dut4 (
      .clk(clk), .reset(reset), .en(en), .ev_valid(ev_valid), .ev_idx(ev_idx),
      .ev_ready(ev_ready4), .clr(clr), .clr_busy(clr_busy4), .rd_en(rd_en),
      .rd_idx(rd_idx), .rd_valid(rd_valid4), .rd_data(rd_data4), .sat(sat4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  v;
      logic [11:0] idx;
      logic        rd_en;
      logic [2:0]  rd_idx;
      logic [3:0]  exp_ready;
      logic        chk_rd;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input logic [2:0] idx, input logic [15:0] e16, input logic [3:0] e4);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en = 1'b0;
      check("rd_valid", 32'(rd_valid), 32'd1);
      check($sformatf("rd_data[%0d]", idx), 32'(rd_data), 32'(e16));
      check($sformatf("rd_data4[%0d]", idx), 32'(rd_data4), 32'(e4));
   endtask

   localparam logic [11:0] IDX_R = 12'h688;   // requester r targets counter r

   logic [2:0]  sweep_idx [8];
   logic [15:0] sweep_exp [8];
   logic [15:0] final_exp [4];

   initial begin
      // {en, valid, idx, rd_en, rd_idx, exp_ready, chk_rd, exp_rd}
      vecs[0]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0001, 1'b0, 16'd0};
      vecs[1]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0010, 1'b0, 16'd0};
      vecs[2]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0100, 1'b0, 16'd0};
      vecs[3]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b1000, 1'b0, 16'd0};
      vecs[4]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0001, 1'b0, 16'd0};
      vecs[5]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0010, 1'b0, 16'd0};
      vecs[6]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0100, 1'b0, 16'd0};
      vecs[7]  = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b1000, 1'b0, 16'd0};
      vecs[8]  = '{1'b1, 4'hA, IDX_R, 1'b1, 3'd0, 4'b0010, 1'b0, 16'd0};
      vecs[9]  = '{1'b1, 4'hA, IDX_R, 1'b1, 3'd3, 4'b1000, 1'b1, 16'd2};
      vecs[10] = '{1'b1, 4'h4, IDX_R, 1'b1, 3'd2, 4'b0100, 1'b1, 16'd2};
      vecs[11] = '{1'b1, 4'h0, IDX_R, 1'b1, 3'd1, 4'b0000, 1'b1, 16'd2};
      vecs[12] = '{1'b1, 4'h3, IDX_R, 1'b0, 3'd0, 4'b0001, 1'b1, 16'd3};
      vecs[13] = '{1'b0, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0000, 1'b0, 16'd0};
      vecs[14] = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0000, 1'b0, 16'd0};
      vecs[15] = '{1'b1, 4'hF, IDX_R, 1'b0, 3'd0, 4'b0010, 1'b0, 16'd0};

      sweep_idx = '{3'd5, 3'd2, 3'd2, 3'd3, 3'd5, 3'd0, 3'd1, 3'd7};
      sweep_exp = '{16'd17, 16'd8, 16'd8, 16'd3, 16'd17, 16'd0, 16'd0, 16'd0};
      final_exp = '{16'd3, 16'd4, 16'd3, 16'd3};

      reset = 1'b1; en = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_idx = '0;
      ev_valid = '0; ev_idx = '0;
      #1;
      check("reset ev_ready", 32'(ev_ready), 32'd0);
      check("reset clr_busy", 32'(clr_busy), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data",  32'(rd_data),  32'd0);
      check("reset sat",      32'(sat),      32'd0);
      tick(); tick();
      reset = 1'b0;

      // Single requester, counter 3, five grants.
      en = 1'b1;
      tick();
      ev_valid = 4'b0001; ev_idx = 12'h003;
      for (int i = 0; i < 5; i++) begin
         #1 check($sformatf("single grant %0d", i), 32'(ev_ready), 32'd1);
         tick();
      end
      ev_valid = '0;
      rd_check(3'd3, 16'd5, 4'd5);

      // Fresh start so the pointer begins at requester 0.
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         en = vecs[i].en; ev_valid = vecs[i].v; ev_idx = vecs[i].idx;
         rd_en = vecs[i].rd_en; rd_idx = vecs[i].rd_idx;
         #1;
         check($sformatf("vec%0d ev_ready", i), 32'(ev_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d ev_ready4", i), 32'(ev_ready4), 32'(vecs[i].exp_ready));
         if (vecs[i].chk_rd) begin
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'd1);
            check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
         end
         tick();
      end
      ev_valid = '0; rd_en = 1'b0;
      for (int i = 0; i < 4; i++) rd_check(3'(i), final_exp[i], final_exp[i][3:0]);

      // Counter 2 to 7, then read it in the same cycle as another increment.
      ev_valid = 4'b0001; ev_idx = 12'h002;
      for (int i = 0; i < 4; i++) begin
         #1 check("fill2 grant", 32'(ev_ready), 32'd1);
         tick();
      end
      rd_en = 1'b1; rd_idx = 3'd2;
      #1 check("rd+inc grant", 32'(ev_ready), 32'd1);
      tick();
      rd_en = 1'b0; ev_valid = '0;
      check("rd+inc pre value", 32'(rd_data), 32'd7);
      rd_check(3'd2, 16'd8, 4'd8);

      // 17 increments of counter 5: the 4-bit instance saturates at 15.
      ev_valid = 4'b0001; ev_idx = 12'h005;
      repeat (17) tick();
      ev_valid = '0;
      check("sat 16b", 32'(sat), 32'd0);
      check("sat 4b",  32'(sat4), 32'h20);
      rd_check(3'd5, 16'd17, 4'd15);

      // Bank clear with requests pending and a second clr ignored mid-sweep.
      clr = 1'b1;
      tick();
      clr = 1'b0; ev_valid = 4'hF; ev_idx = IDX_R;
      for (int k = 0; k < 8; k++) begin
         clr = (k == 3); rd_en = 1'b1; rd_idx = sweep_idx[k];
         #1;
         check($sformatf("sweep%0d busy", k), 32'(clr_busy), 32'd1);
         check($sformatf("sweep%0d busy4", k), 32'(clr_busy4), 32'd1);
         check($sformatf("sweep%0d ev_ready", k), 32'(ev_ready), 32'd0);
         if (k > 0) check($sformatf("sweep%0d rd_data", k), 32'(rd_data), 32'(sweep_exp[k-1]));
         tick();
      end
      clr = 1'b0; rd_en = 1'b0;
      #1;
      check("sweep7 rd_data", 32'(rd_data), 32'(sweep_exp[7]));
      check("clear done busy", 32'(clr_busy), 32'd0);
      check("first grant after clear", 32'(ev_ready), 32'b0010);
      ev_valid = '0;
      for (int i = 0; i < 8; i++) rd_check(3'(i), 16'd0, 4'd0);
      check("sat cleared", 32'(sat), 32'd0);
      check("sat4 cleared", 32'(sat4), 32'd0);

      // Saturate counter 7 in the 4-bit bank, then reset in the middle of a clear.
      ev_valid = 4'b0001; ev_idx = 12'h007;
      repeat (16) tick();
      ev_valid = '0;
      check("sat4 idx7", 32'(sat4), 32'h80);
      en = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0; ev_valid = 4'hF; ev_idx = IDX_R;
      for (int k = 0; k < 3; k++) begin
         rd_en = (k == 2); rd_idx = 3'd7;
         #1 check($sformatf("pre-reset busy%0d", k), 32'(clr_busy), 32'd1);
         tick();
      end
      rd_en = 1'b0;
      check("pre-reset rd_valid", 32'(rd_valid), 32'd1);
      check("pre-reset rd_data", 32'(rd_data), 32'd16);
      #2 reset = 1'b1;
      #1;
      check("async clr_busy", 32'(clr_busy), 32'd0);
      check("async ev_ready", 32'(ev_ready), 32'd0);
      check("async rd_valid", 32'(rd_valid), 32'd0);
      check("async rd_data",  32'(rd_data),  32'd0);
      check("async sat4",     32'(sat4),     32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post-reset ev_ready%0d", i), 32'(ev_ready), 32'd0);
         check($sformatf("post-reset busy%0d", i), 32'(clr_busy), 32'd0);
      end
      ev_valid = '0;
      rd_check(3'd7, 16'd0, 4'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
